// File: rtl/ctle_fz_pkg.sv
// Shared types and constants for the CTLE zero-frequency (v_fz) sequencer and its users.
package ctle_fz_pkg;

    localparam int unsigned CODE_W = 6;
    localparam logic [CODE_W-1:0] CODE_MIN = CODE_W'(7);
    localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(56);
    localparam real VLSB = 0.028125;

    typedef enum logic [1:0] {
        FZ_IDLE,
        FZ_RAMP,
        FZ_SETTLE
    } fz_state_t;

    // Limit any requested code to the legal v_fz window.
    function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] code);
        logic [CODE_W-1:0] res;
        res = code;
        if (code < CODE_MIN) begin
            res = CODE_MIN;
        end else if (code > CODE_MAX) begin
            res = CODE_MAX;
        end
        return res;
    endfunction

endpackage

// File: rtl/ctle_fz_timer.sv
// Loadable down-counter with terminal-count flag; holds at zero until reloaded.
module ctle_fz_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_c_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c_o = (cnt_q == '0);

endmodule

// File: rtl/ctle_fz_seq.sv
// v_fz code sequencer: accepts clamped targets, slews in bounded steps, settles, pulses done.
module ctle_fz_seq
    import ctle_fz_pkg::*;
#(
    parameter logic [CODE_W-1:0] RESET_CODE    = CODE_W'(28),
    parameter int unsigned       STEP          = 2,
    parameter int unsigned       RAMP_DIV      = 4,
    parameter int unsigned       SETTLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [CODE_W-1:0] req_code,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic              req_clamped,
    output logic [CODE_W-1:0] fz_code,
    output real               v_fz
);

    localparam int unsigned SW      = CODE_W + 1;
    localparam int unsigned TMR_MAX = (SETTLE_CYCLES > RAMP_DIV) ? SETTLE_CYCLES : RAMP_DIV;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic signed [SW-1:0] STEP_S = SW'(STEP);

    if ((RESET_CODE < CODE_MIN) || (RESET_CODE > CODE_MAX)) begin : g_bad_reset_code
        $error("ctle_fz_seq: RESET_CODE outside [CODE_MIN,CODE_MAX]");
    end
    if ((RAMP_DIV < 1) || (SETTLE_CYCLES < 1)) begin : g_bad_timing
        $error("ctle_fz_seq: RAMP_DIV and SETTLE_CYCLES must be >= 1");
    end

    fz_state_t         state_q, state_d;
    logic [CODE_W-1:0] fz_code_q, fz_code_d;
    logic [CODE_W-1:0] target_q, target_d;
    logic              clamped_q, clamped_d;
    logic              done_q, done_d;

    logic              rtmr_load, stmr_load, rtmr_tc, stmr_tc;
    logic [TMR_W-1:0]  rtmr_val, stmr_val;
    logic [CODE_W-1:0] req_target;
    logic [CODE_W-1:0] step_code;
    logic signed [SW-1:0] cur_s, tgt_s, diff_s, up_s, dn_s;

    // Next ramp code, computed one bit wider and signed so the step never wraps.
    assign cur_s  = $signed({1'b0, fz_code_q});
    assign tgt_s  = $signed({1'b0, target_q});
    assign diff_s = tgt_s - cur_s;
    assign up_s   = cur_s + STEP_S;
    assign dn_s   = cur_s - STEP_S;

    always_comb begin
        step_code = target_q;
        if (diff_s > STEP_S) begin
            step_code = CODE_W'(up_s);
        end else if (diff_s < -STEP_S) begin
            step_code = CODE_W'(dn_s);
        end
    end

    assign req_target = clamp_code(req_code);
    assign rtmr_val   = TMR_W'(RAMP_DIV - 1);
    assign stmr_val   = TMR_W'(SETTLE_CYCLES - 1);

    always_comb begin
        state_d   = state_q;
        fz_code_d = fz_code_q;
        target_d  = target_q;
        clamped_d = clamped_q;
        done_d    = 1'b0;
        rtmr_load = 1'b0;
        stmr_load = 1'b0;
        case (state_q)
            FZ_IDLE: begin
                if (req_valid) begin
                    target_d  = req_target;
                    clamped_d = (req_code < CODE_MIN) || (req_code > CODE_MAX);
                    rtmr_load = 1'b1;
                    stmr_load = 1'b1;
                    state_d   = (req_target == fz_code_q) ? FZ_SETTLE : FZ_RAMP;
                end
            end
            FZ_RAMP: begin
                if (rtmr_tc) begin
                    fz_code_d = step_code;
                    rtmr_load = 1'b1;
                    if (step_code == target_q) begin
                        state_d   = FZ_SETTLE;
                        stmr_load = 1'b1;
                    end
                end
            end
            FZ_SETTLE: begin
                if (stmr_tc) begin
                    state_d = FZ_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = FZ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FZ_IDLE;
            fz_code_q <= RESET_CODE;
            target_q  <= RESET_CODE;
            clamped_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fz_code_q <= fz_code_d;
            target_q  <= target_d;
            clamped_q <= clamped_d;
            done_q    <= done_d;
        end
    end

    ctle_fz_timer #(.W(TMR_W)) u_ramp_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rtmr_load),
        .load_val_i (rtmr_val),
        .en_i       (state_q == FZ_RAMP),
        .tc_c_o     (rtmr_tc)
    );

    ctle_fz_timer #(.W(TMR_W)) u_settle_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (stmr_load),
        .load_val_i (stmr_val),
        .en_i       (state_q == FZ_SETTLE),
        .tc_c_o     (stmr_tc)
    );

    // Ready is withheld while reset is asserted so nothing is offered before release.
    assign req_ready   = (state_q == FZ_IDLE) && !rst;
    assign busy        = (state_q != FZ_IDLE);
    assign done        = done_q;
    assign req_clamped = clamped_q;
    assign fz_code     = fz_code_q;
    assign v_fz        = real'(fz_code_q) * VLSB;

endmodule

// File: tb/tb_ctle_fz_seq.sv
// Directed bench for ctle_fz_seq: reset, ramps, clamping, no-move, busy blocking, abort.
module tb_ctle_fz_seq;
    import ctle_fz_pkg::*;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic [CODE_W-1:0] req_code;
    logic              req_ready;
    logic              busy;
    logic              done;
    logic              req_clamped;
    logic [CODE_W-1:0] fz_code;
    real               v_fz;

    int n_chk  = 0;
    int n_pass = 0;

    ctle_fz_seq dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_code    (req_code),
        .req_ready   (req_ready),
        .busy        (busy),
        .done        (done),
        .req_clamped (req_clamped),
        .fz_code     (fz_code),
        .v_fz        (v_fz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_v(input string tag, input real obs, input real exp);
        n_chk++;
        assert (((obs - exp) < 1.0e-6) && ((exp - obs) < 1.0e-6)) n_pass++;
        else $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    endtask

    // Reference slew: move two codes toward the target, landing exactly when close.
    function automatic int move(input int cur, input int tgt);
        if (tgt > cur + 2) return cur + 2;
        if (cur > tgt + 2) return cur - 2;
        return tgt;
    endfunction

    task automatic send(input int code);
        req_valid = 1'b1;
        req_code  = CODE_W'(code);
        tick();
        req_valid = 1'b0;
    endtask

    // Starts just after the accept edge; checks hold and step on each 4-cycle boundary.
    task automatic ramp_check(input string tag, input int from, input int tgt);
        int e;
        int prev;
        e = from;
        while (e != tgt) begin
            prev = e;
            e = move(e, tgt);
            repeat (3) tick();
            chk({tag, "_hold"}, int'(fz_code), prev);
            tick();
            chk({tag, "_step"}, int'(fz_code), e);
            chk({tag, "_rdy"}, int'(req_ready), 0);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((done !== 1'b1) && (n < 100));
        chk({tag, "_latency"}, n, exp_cycles);
        chk({tag, "_ready"}, int'(req_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_code"}, int'(fz_code), 28);
        chk({tag, "_busy"}, int'(busy), 0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int n_done;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_code  = '0;
        #1 rst = 1'b1;

        // 1 reset
        tick();
        tick();
        chk("rst_code", int'(fz_code), 28);
        chk_v("rst_vfz", v_fz, 0.7875);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_clamped", int'(req_clamped), 0);
        rst = 1'b0;
        tick();
        chk("rel_ready", int'(req_ready), 1);

        // 2 ramp up with odd distance
        send(33);
        chk("r33_busy", int'(busy), 1);
        chk("r33_ready", int'(req_ready), 0);
        repeat (3) tick();
        chk("r33_hold", int'(fz_code), 28);
        tick();
        chk("r33_s1", int'(fz_code), 30);
        repeat (4) tick();
        chk("r33_s2", int'(fz_code), 32);
        repeat (4) tick();
        chk("r33_s3", int'(fz_code), 33);
        wait_done("r33", 16);
        chk("r33_clamped", int'(req_clamped), 0);
        tick();
        chk("r33_done_pulse", int'(done), 0);

        // 3 clamping at both ends of the window
        send(63);
        chk("r63_clamped", int'(req_clamped), 1);
        ramp_check("r63", 33, 56);
        chk_v("r63_vfz", v_fz, 1.575);
        wait_done("r63", 16);
        chk("r63_clamped_held", int'(req_clamped), 1);
        send(0);
        chk("r0_clamped", int'(req_clamped), 1);
        ramp_check("r0", 56, 7);
        chk_v("r0_vfz", v_fz, 0.196875);
        wait_done("r0", 16);

        // 4 no-move request settles directly
        reset_pulse("rst2");
        send(28);
        chk("r28_busy", int'(busy), 1);
        chk("r28_clamped", int'(req_clamped), 0);
        wait_done("r28", 16);
        chk("r28_code", int'(fz_code), 28);

        // 5 second request held during ramp is accepted in the done cycle
        tick();
        req_valid = 1'b1;
        req_code  = CODE_W'(40);
        tick();
        req_code  = CODE_W'(10);
        chk("r40_busy", int'(busy), 1);
        ramp_check("r40", 28, 40);
        wait_done("r40", 16);
        tick();
        req_valid = 1'b0;
        chk("r10_accept_busy", int'(busy), 1);
        chk("r10_done_low", int'(done), 0);
        ramp_check("r10", 40, 10);
        wait_done("r10", 16);
        chk("r10_code", int'(fz_code), 10);

        // 6 reset mid-ramp aborts without done
        reset_pulse("rst3");
        send(50);
        repeat (13) tick();
        chk("r50_mid", int'(fz_code), 34);
        #2 rst = 1'b1;
        #1;
        chk("abort_code", int'(fz_code), 28);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        tick();
        rst = 1'b0;
        n_done = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        send(30);
        ramp_check("r30", 28, 30);
        wait_done("r30", 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
